// File: rtl/print_arbiter.sv
// print_arbiter: round-robin arbiter sharing one card renderer among NREQ requesters.
// Clear-screen (init) requests take priority; accepted commands are queued in an
// in-order FIFO and issued with a write/waitrequest handshake.
module print_arbiter #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_init,
   input  logic [6*NREQ-1:0]        req_card,
   input  logic [15*NREQ-1:0]       req_orig,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rnd_write,
   output logic                     rnd_init,
   output logic [5:0]               rnd_card,
   output logic [14:0]              rnd_orig,
   input  logic                     rnd_waitrequest,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic        init;
      logic [5:0]  card;
      logic [14:0] orig;
   } cmd_t;

   cmd_t          mem_q [DEPTH];
   cmd_t          mem_d [DEPTH];
   cmd_t          head_q, head_d;
   cmd_t          push_cmd;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   logic          full;
   logic          gnt_valid;
   logic          gnt_init;
   logic [PW-1:0] gnt_idx;
   logic          push;
   logic          pop;

   assign full = (count_q == CW'(DEPTH));

   // Grant: lowest-index init request wins, else round-robin from rr_ptr; nothing while full.
   always_comb begin
      int unsigned idx;
      gnt_valid = 1'b0;
      gnt_init  = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      if (rst_n && !full) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!gnt_valid && req_valid[i] && req_init[i]) begin
               gnt_valid = 1'b1;
               gnt_init  = 1'b1;
               gnt_idx   = PW'(i);
            end
         end
         for (int k = 0; k < int'(NREQ); k++) begin
            idx = (32'(rr_ptr_q) + 32'(k)) % NREQ;
            if (!gnt_valid && req_valid[idx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = PW'(idx);
            end
         end
      end
      req_ready          = '0;
      req_ready[gnt_idx] = gnt_valid;
      push_cmd.init      = gnt_init;
      push_cmd.card      = req_card[6*int'(gnt_idx) +: 6];
      push_cmd.orig      = req_orig[15*int'(gnt_idx) +: 15];
   end

   // Next-state for round-robin pointer, FIFO pointers/storage and head register.
   always_comb begin
      push     = gnt_valid;
      pop      = (count_q != '0) && !rnd_waitrequest;
      rr_ptr_d = rr_ptr_q;
      if (gnt_valid && !gnt_init) begin
         rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_cmd;
      end
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      // Head holds its last value when the FIFO drains; bypass a push into an empty queue.
      head_d = head_q;
      if (count_d != '0) begin
         if (push && (count_q == CW'(pop))) begin
            head_d = push_cmd;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
         head_q   <= head_d;
      end
   end

   // Storage needs no reset: pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rnd_write  = (count_q != '0);
   assign rnd_init   = head_q.init;
   assign rnd_card   = head_q.card;
   assign rnd_orig   = head_q.orig;
   assign fifo_count = count_q;
   assign busy       = (count_q != '0);

endmodule

// File: tb/tb_print_arbiter.sv
// Directed bench for print_arbiter (NREQ=3, DEPTH=4): vector table plus hand sequences.
module tb_print_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [2:0]  req_init;
   logic [17:0] req_card;
   logic [44:0] req_orig;
   logic [2:0]  req_ready;
   logic        rnd_write;
   logic        rnd_init;
   logic [5:0]  rnd_card;
   logic [14:0] rnd_orig;
   logic        rnd_waitrequest;
   logic [2:0]  fifo_count;
   logic        busy;

   int n_vec;
   int n_bad;

   print_arbiter #(.NREQ(3), .DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_init        (req_init),
      .req_card        (req_card),
      .req_orig        (req_orig),
      .req_ready       (req_ready),
      .rnd_write       (rnd_write),
      .rnd_init        (rnd_init),
      .rnd_card        (rnd_card),
      .rnd_orig        (rnd_orig),
      .rnd_waitrequest (rnd_waitrequest),
      .fifo_count      (fifo_count),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;
      logic [2:0] in;
      logic [5:0] c0, c1, c2;
      logic       w;
      logic [2:0] rdy;
      logic       wr;
      logic       ini;
      logic [5:0] card;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0] in,
                               input logic [5:0] c0, input logic [5:0] c1,
                               input logic [5:0] c2, input logic w,
                               input logic [2:0] rdy, input logic wr, input logic ini,
                               input logic [5:0] card, input logic [2:0] cnt);
      vec_t r;
      r.v = v; r.in = in; r.c0 = c0; r.c1 = c1; r.c2 = c2; r.w = w;
      r.rdy = rdy; r.wr = wr; r.ini = ini; r.card = card; r.cnt = cnt;
      return r;
   endfunction

   // Origin derived from the card so each command is self-identifying.
   function automatic logic [14:0] orig_of(input logic [5:0] c);
      return {2'b00, c, 1'b0, c};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Wait for the inactive edge, then drive one cycle's inputs.
   task automatic drive(input logic [2:0] v, input logic [2:0] in, input logic [5:0] c0,
                        input logic [5:0] c1, input logic [5:0] c2, input logic w);
      @(negedge clk);
      req_valid       = v;
      req_init        = in;
      req_card        = {c2, c1, c0};
      req_orig        = {orig_of(c2), orig_of(c1), orig_of(c0)};
      rnd_waitrequest = w;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] rdy, input logic wr,
                          input logic ini, input logic [5:0] card, input logic [2:0] cnt);
      chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".write"}, 32'(rnd_write), 32'(wr));
      chk({tag, ".count"}, 32'(fifo_count), 32'(cnt));
      chk({tag, ".busy"}, 32'(busy), 32'(cnt != 3'd0));
      if (wr) begin
         chk({tag, ".init"}, 32'(rnd_init), 32'(ini));
         if (!ini) begin
            chk({tag, ".card"}, 32'(rnd_card), 32'(card));
            chk({tag, ".orig"}, 32'(rnd_orig), 32'(orig_of(card)));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      req_valid = '0; req_init = '0; req_card = '0; req_orig = '0; rnd_waitrequest = 1'b0;

      // Round robin, then init priority and pointer behaviour after init grants.
      tbl[0]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b001, 1'b0, 1'b0, 6'd0,  3'd0);
      tbl[1]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b010, 1'b1, 1'b0, 6'd10, 3'd1);
      tbl[2]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b100, 1'b1, 1'b0, 6'd11, 3'd1);
      tbl[3]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b001, 1'b1, 1'b0, 6'd12, 3'd1);
      tbl[4]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b010, 1'b1, 1'b0, 6'd10, 3'd1);
      tbl[5]  = mk(3'b111, 3'b000, 6'd10, 6'd11, 6'd12, 1'b0, 3'b100, 1'b1, 1'b0, 6'd11, 3'd1);
      tbl[6]  = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b1, 1'b0, 6'd12, 3'd1);
      tbl[7]  = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b0, 1'b0, 6'd0,  3'd0);
      tbl[8]  = mk(3'b001, 3'b000, 6'd20, 6'd0,  6'd0,  1'b0, 3'b001, 1'b0, 1'b0, 6'd0,  3'd0);
      tbl[9]  = mk(3'b110, 3'b100, 6'd0,  6'd21, 6'd22, 1'b0, 3'b100, 1'b1, 1'b0, 6'd20, 3'd1);
      tbl[10] = mk(3'b010, 3'b000, 6'd0,  6'd21, 6'd0,  1'b0, 3'b010, 1'b1, 1'b1, 6'd0,  3'd1);
      tbl[11] = mk(3'b011, 3'b000, 6'd23, 6'd24, 6'd0,  1'b0, 3'b001, 1'b1, 1'b0, 6'd21, 3'd1);
      tbl[12] = mk(3'b111, 3'b110, 6'd25, 6'd26, 6'd27, 1'b0, 3'b010, 1'b1, 1'b0, 6'd23, 3'd1);
      tbl[13] = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b1, 1'b1, 6'd0,  3'd1);
      tbl[14] = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b0, 1'b0, 6'd0,  3'd0);
      tbl[15] = mk(3'b111, 3'b000, 6'd30, 6'd31, 6'd32, 1'b0, 3'b010, 1'b0, 1'b0, 6'd0,  3'd0);
      tbl[16] = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b1, 1'b0, 6'd31, 3'd1);
      tbl[17] = mk(3'b000, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 3'b000, 1'b0, 1'b0, 6'd0,  3'd0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_out("reset", 3'b000, 1'b0, 1'b0, 6'd0, 3'd0);
      chk("reset.card", 32'(rnd_card), 32'd0);
      chk("reset.orig", 32'(rnd_orig), 32'd0);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].in, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].w);
         #1;
         chk_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].wr, tbl[i].ini, tbl[i].card,
                 tbl[i].cnt);
      end

      // Single request: rr_ptr is 2 here, so the search wraps round to requester 0.
      drive(3'b001, 3'b000, 6'd6, 6'd0, 6'd0, 1'b0);
      req_orig[14:0] = {8'd2, 7'd2};
      #1;
      chk("single.ready", 32'(req_ready), 32'b001);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk("single.write", 32'(rnd_write), 32'd1);
      chk("single.card", 32'(rnd_card), 32'd6);
      chk("single.orig", 32'(rnd_orig), 32'h0102);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk("single.idle", 32'(rnd_write), 32'd0);
      chk("single.hold", 32'(rnd_card), 32'd6);

      // Backpressure: five commands from requester 0 into a stalled renderer.
      for (int k = 0; k < 6; k++) begin
         drive(3'b001, 3'b000, 6'(40 + ((k < 4) ? k : 4)), 6'd0, 6'd0, 1'b1);
         #1;
         chk_out($sformatf("bp%0d", k), (k < 4) ? 3'b001 : 3'b000, k > 0, 1'b0, 6'd40,
                 3'((k < 4) ? k : 4));
      end
      drive(3'b001, 3'b000, 6'd44, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("bp_pop1", 3'b000, 1'b1, 1'b0, 6'd40, 3'd4);
      drive(3'b001, 3'b000, 6'd44, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("bp_fifth", 3'b001, 1'b1, 1'b0, 6'd41, 3'd3);
      for (int k = 0; k < 4; k++) begin
         drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
         #1;
         chk_out($sformatf("bp_drain%0d", k), 3'b000, k < 3, 1'b0, 6'(42 + k),
                 3'((k == 0) ? 3 : 3 - k));
      end

      // Simultaneous push and pop at occupancy 2.
      drive(3'b001, 3'b000, 6'd50, 6'd0, 6'd0, 1'b1);
      #1;
      chk_out("pp0", 3'b001, 1'b0, 1'b0, 6'd0, 3'd0);
      drive(3'b001, 3'b000, 6'd51, 6'd0, 6'd0, 1'b1);
      #1;
      chk_out("pp1", 3'b001, 1'b1, 1'b0, 6'd50, 3'd1);
      drive(3'b001, 3'b000, 6'd52, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("pp2", 3'b001, 1'b1, 1'b0, 6'd50, 3'd2);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("pp3", 3'b000, 1'b1, 1'b0, 6'd51, 3'd2);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("pp4", 3'b000, 1'b1, 1'b0, 6'd52, 3'd1);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("pp5", 3'b000, 1'b0, 1'b0, 6'd0, 3'd0);

      // Reset with a full FIFO; rr_ptr is 1 beforehand, so a grant to 0 proves it cleared.
      for (int k = 0; k < 4; k++) begin
         drive(3'b001, 3'b000, 6'(60 + k), 6'd0, 6'd0, 1'b1);
         #1;
      end
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1);
      #1;
      chk("rstfull.count", 32'(fifo_count), 32'd4);
      rst_n = 1'b0;
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk_out("rstfull", 3'b000, 1'b0, 1'b0, 6'd0, 3'd0);
      chk("rstfull.init", 32'(rnd_init), 32'd0);
      chk("rstfull.card", 32'(rnd_card), 32'd0);
      chk("rstfull.orig", 32'(rnd_orig), 32'd0);
      drive(3'b111, 3'b000, 6'd70, 6'd71, 6'd72, 1'b0);
      #1;
      chk("rstfull.rr", 32'(req_ready), 32'b001);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("rstfull.after", 3'b000, 1'b1, 1'b0, 6'd70, 3'd1);
      drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
      #1;
      chk_out("rstfull.empty", 3'b000, 1'b0, 1'b0, 6'd0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
